// File: rtl/muldiv_ctrl_pkg.sv
// Shared funct codes, FSM states and sign-fixup helper for the multiply/divide sequencer.
package muldiv_ctrl_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1a;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    MULDIV_IDLE = 2'd0,
    MULDIV_CALC = 2'd1,
    MULDIV_DONE = 2'd2
  } muldiv_state_e;

  typedef struct packed {
    logic is_div;
    logic sign_a;
    logic sign_b;
  } muldiv_op_t;

  function automatic logic is_muldiv(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) || (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

  // raw is {hi, lo}: product for multiply, {remainder, quotient} for divide
  function automatic logic [2*DATA_W-1:0] sign_fixup(input logic is_div, input logic sign_a,
                                                     input logic sign_b,
                                                     input logic [2*DATA_W-1:0] raw);
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   quo;
    logic [2*DATA_W-1:0] res;
    rem = raw[2*DATA_W-1:DATA_W];
    quo = raw[DATA_W-1:0];
    if (is_div) begin
      if (sign_a ^ sign_b) quo = -quo;
      if (sign_a) rem = -rem;
      res = {rem, quo};
    end else begin
      res = (sign_a ^ sign_b) ? -raw : raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_radix2_step.sv
// One restoring-division step on the {remainder, quotient} working register.
module div_radix2_step
  import muldiv_ctrl_pkg::*;
(
  input  logic [2*DATA_W-1:0] work,
  input  logic [DATA_W-1:0]   divisor,
  output logic [2*DATA_W-1:0] next_work_c
);

  logic [DATA_W:0] shifted_rem;
  logic [DATA_W:0] diff;

  // 33-bit compare: the shifted remainder can reach 2*divisor-1
  assign shifted_rem = {work[2*DATA_W-1:DATA_W], work[DATA_W-1]};
  assign diff        = shifted_rem - {1'b0, divisor};

  always_comb begin
    next_work_c = {shifted_rem[DATA_W-1:0], work[DATA_W-2:0], 1'b0};
    if (shifted_rem >= {1'b0, divisor}) begin
      next_work_c = {diff[DATA_W-1:0], work[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with EX stall request and HI/LO write strobe.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply, two-cycle MULT/MULTU latency.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [DATA_W-1:0]  operand_1,
  input  logic [DATA_W-1:0]  operand_2,
  input  logic               flush,
  output logic               stall_req,
  output logic               busy,
  output logic               hilo_write_en,
  output logic [DATA_W-1:0]  hi_out,
  output logic [DATA_W-1:0]  lo_out
);

  localparam int unsigned CNT_W = $clog2(DIV_ITERS) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

  muldiv_state_e       state;
  muldiv_op_t          op;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] work;
  logic [DATA_W-1:0]   opb;

  logic                start_c;
  logic                op_div_c;
  logic                op_signed_c;
  logic                sign_a_c;
  logic                sign_b_c;
  logic                div_zero_c;
  logic [DATA_W-1:0]   mag1_c;
  logic [DATA_W-1:0]   mag2_c;
  logic [2*DATA_W-1:0] div_next_c;
  logic [DATA_W:0]     mul_sum_c;
  logic [2*DATA_W-1:0] mul_next_c;
  logic [2*DATA_W-1:0] calc_next_c;
  logic [2*DATA_W-1:0] result_c;

  // Operand decode and magnitude extraction for the start edge
  assign start_c     = is_muldiv(funct) && !flush;
  assign op_div_c    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
  assign op_signed_c = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign sign_a_c    = op_signed_c && operand_1[DATA_W-1];
  assign sign_b_c    = op_signed_c && operand_2[DATA_W-1];
  assign mag1_c      = sign_a_c ? -operand_1 : operand_1;
  assign mag2_c      = sign_b_c ? -operand_2 : operand_2;
  assign div_zero_c  = op_div_c && (operand_2 == '0);

  assign stall_req = !flush && (((state == MULDIV_IDLE) && start_c) || (state == MULDIV_CALC));

  div_radix2_step u_div_step (
    .work        (work),
    .divisor     (opb),
    .next_work_c (div_next_c)
  );

  // Shift-add multiply: multiplier consumed from the low half, product fills from the top
  assign mul_sum_c   = {1'b0, work[2*DATA_W-1:DATA_W]} + ({1'b0, opb} & {(DATA_W+1){work[0]}});
  assign mul_next_c  = {mul_sum_c, work[DATA_W-1:1]};
  assign calc_next_c = op.is_div ? div_next_c : mul_next_c;
  assign result_c    = sign_fixup(op.is_div, op.sign_a, op.sign_b, calc_next_c);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*DATA_W-1:0] fast_prod_c;
  assign fast_prod_c = (2*DATA_W)'(mag1_c) * (2*DATA_W)'(mag2_c);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= MULDIV_IDLE;
      op            <= '0;
      cnt           <= '0;
      work          <= '0;
      opb           <= '0;
      busy          <= 1'b0;
      hilo_write_en <= 1'b0;
      hi_out        <= '0;
      lo_out        <= '0;
    end else begin
      hilo_write_en <= 1'b0;
      if (flush) begin
        state <= MULDIV_IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          MULDIV_IDLE: begin
            if (start_c) begin
              op   <= '{is_div: op_div_c, sign_a: sign_a_c, sign_b: sign_b_c};
              cnt  <= '0;
              opb  <= op_div_c ? mag2_c : mag1_c;
              work <= {{DATA_W{1'b0}}, (op_div_c ? mag1_c : mag2_c)};
              busy <= 1'b1;
              if (div_zero_c) begin
                state         <= MULDIV_DONE;
                hi_out        <= operand_1;
                lo_out        <= '1;
                hilo_write_en <= 1'b1;
              end
`ifdef MULDIV_FAST_MUL_EN
              else if (!op_div_c) begin
                state              <= MULDIV_DONE;
                work               <= fast_prod_c;
                {hi_out, lo_out}   <= sign_fixup(1'b0, sign_a_c, sign_b_c, fast_prod_c);
                hilo_write_en      <= 1'b1;
              end
`endif
              else begin
                state <= MULDIV_CALC;
              end
            end
          end
          MULDIV_CALC: begin
            work <= calc_next_c;
            cnt  <= cnt + CNT_W'(1);
            if (cnt == LAST_ITER) begin
              state            <= MULDIV_DONE;
              {hi_out, lo_out} <= result_c;
              hilo_write_en    <= 1'b1;
            end
          end
          MULDIV_DONE: begin
            state <= MULDIV_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= MULDIV_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (latency follows MULDIV_FAST_MUL_EN).
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_CYC = 2;
`else
  localparam int MUL_CYC = 34;
`endif
  localparam int DIV_CYC = 34;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               flush = 1'b0;
  logic [FUNCT_W-1:0] funct = '0;
  logic [DATA_W-1:0]  operand_1 = '0;
  logic [DATA_W-1:0]  operand_2 = '0;
  logic               stall_req;
  logic               busy;
  logic               hilo_write_en;
  logic [DATA_W-1:0]  hi_out;
  logic [DATA_W-1:0]  lo_out;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .funct         (funct),
    .operand_1     (operand_1),
    .operand_2     (operand_2),
    .flush         (flush),
    .stall_req     (stall_req),
    .busy          (busy),
    .hilo_write_en (hilo_write_en),
    .hi_out        (hi_out),
    .lo_out        (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, count stall cycles and EX occupancy up to the write strobe, check the result
  task automatic run_op(input string tag, input logic [FUNCT_W-1:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_cyc, input bit b2b);
    int stalls = 0;
    int cycles = 0;
    bit got = 1'b0;
    logic [31:0] hi_s = '0;
    logic [31:0] lo_s = '0;
    if (!b2b) @(negedge clk);
    funct = f; operand_1 = a; operand_2 = b;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (stall_req) stalls++;
      cycles++;
      if (hilo_write_en) begin
        got = 1'b1; hi_s = hi_out; lo_s = lo_out;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_strobe"}, 64'(got), 64'(1));
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_cyc - 1));
    check({tag, "_ex_cycles"}, 64'(cycles), 64'(exp_cyc));
    check({tag, "_hi"}, 64'(hi_s), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo_s), 64'(exp_lo));
    @(negedge clk);
    funct = '0;
    #1;
    check({tag, "_idle_after"}, 64'({busy, hilo_write_en, stall_req}), 64'(0));
  endtask

  initial begin
    bit wen_seen;

    #2 rst = 1'b0;
    #1;
    check("reset_stall", 64'(stall_req), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_wen", 64'(hilo_write_en), 64'(0));
    check("reset_hi", 64'(hi_out), 64'(0));
    check("reset_lo", 64'(lo_out), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op("divu_100_7", FUNCT_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_CYC, 1'b0);
    run_op("div_m7_2", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYC, 1'b0);

    // Flush at CALC iteration 10
    @(negedge clk);
    funct = FUNCT_DIVU; operand_1 = 32'd1000; operand_2 = 32'd3;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_stall_same_cycle", 64'(stall_req), 64'(0));
    check("flush_busy_before", 64'(busy), 64'(1));
    @(negedge clk);
    flush = 1'b0; funct = '0;
    #1;
    check("flush_busy_after", 64'(busy), 64'(0));
    check("flush_hi_kept", 64'(hi_out), 64'(32'hFFFF_FFFF));
    check("flush_lo_kept", 64'(lo_out), 64'(32'hFFFF_FFFD));
    wen_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (hilo_write_en || busy) wen_seen = 1'b1;
    end
    check("flush_no_write", 64'(wen_seen), 64'(0));

    run_op("mult_m1_2", FUNCT_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_CYC, 1'b0);
    run_op("multu_max_2", FUNCT_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MUL_CYC, 1'b0);
    run_op("multu_max_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
           MUL_CYC, 1'b0);
    run_op("div_5_0", FUNCT_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 2, 1'b0);
    run_op("div_min_m1", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_CYC, 1'b0);

    // Back-to-back: second op enters EX the cycle after DONE
    run_op("divu_max_16", FUNCT_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 32'h0FFF_FFFF, DIV_CYC, 1'b0);
    run_op("b2b_mult_m3_5", FUNCT_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_CYC, 1'b1);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    funct = FUNCT_DIVU; operand_1 = 32'd100; operand_2 = 32'd7;
    repeat (6) @(negedge clk);
    check("rst_mid_busy_before", 64'(busy), 64'(1));
    #2;
    rst = 1'b0; funct = '0;
    #1;
    check("rst_mid_stall", 64'(stall_req), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_wen", 64'(hilo_write_en), 64'(0));
    check("rst_mid_hi", 64'(hi_out), 64'(0));
    check("rst_mid_lo", 64'(lo_out), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
